// File: rtl/fp_adder_rr_arbiter_pkg.sv
// Shared definitions for the FP8 adder arbiter: FSM state encodings and the FP8 word layout.
package fp_adder_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Bit 7 sign, bits 6:4 exponent, bits 3:0 mantissa.
  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [3:0] mant;
  } fp8_t;

endpackage

// File: rtl/fp_adder_rr_arbiter_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping mod N.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_adder_rr_arbiter.sv
// Shares one FP8 adder between NUM_REQ requesters: round-robin grant, operand capture,
// start pulse, bounded wait for completion and one-cycle result return to the owner.
module fp_adder_rr_arbiter
  import fp_adder_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32,
  localparam int OWNER_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_sum,
  output logic                 resp_err,
  output logic                 add_start,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [7:0]           add_sum,
  input  logic                 add_done,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner
);

  logic [1:0]         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  fp8_t               a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [7:0]         resp_sum_q, resp_sum_d;
  logic               resp_err_q, resp_err_d;
  logic               add_start_q, add_start_d;
  logic               busy_q, busy_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               found;
  logic [OWNER_W-1:0] pick_idx;
  logic [OWNER_W-1:0] next_ptr;

  rr_priority_picker #(.N(NUM_REQ), .W(OWNER_W)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  // The finishing owner drops to lowest priority for the next arbitration.
  assign next_ptr = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_sum_d   = resp_sum_q;
    resp_err_d   = 1'b0;
    add_start_d  = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d               = pick_idx;
          a_d                   = fp8_t'(req_a[8*int'(pick_idx) +: 8]);
          b_d                   = fp8_t'(req_b[8*int'(pick_idx) +: 8]);
          req_ready_d[pick_idx] = 1'b1;
          add_start_d           = 1'b1;
          state_d               = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A completion landing on the last allowed cycle still counts as a normal result.
        if (add_done || cnt_q == 8'(TIMEOUT - 1)) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_err_d            = ~add_done;
          resp_sum_d            = add_done ? add_sum : 8'h00;
          ptr_d                 = next_ptr;
          state_d               = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_sum_q   <= '0;
      resp_err_q   <= 1'b0;
      add_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_err_q   <= resp_err_d;
      add_start_q  <= add_start_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_err   = resp_err_q;
  assign add_start  = add_start_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule
